enemy_control: RTL

Sequencing FSM that sits directly upstream of the `enemies` block and drives its phase strobes `init`, `idle`, `gen_move`, `apply_move` and `draw` once per video frame. It divides the frame rate down to the enemy movement rate and arbitrates for the shared VGA write port. It consumes `draw_done` to close each frame, and guards against a stalled draw with a timeout.

---
 rtl/enemy_ctrl_pkg.sv | 7 +
 rtl/enemy_control_if.sv | 13 +
 rtl/frame_divider.sv | 16 +
 rtl/enemy_control.sv | 70 +++++++
 4 files changed

// File: rtl/enemy_ctrl_pkg.sv
// enemy_ctrl_pkg: shared state encoding and default timing constants for frame sequencers
package enemy_ctrl_pkg;
  typedef enum logic [2:0] {INIT, IDLE, GEN_MOVE, APPLY_MOVE, REQ, DRAW, DONE} state_t;
  localparam int DEF_MOVE_DIV = 4;
  localparam int DEF_INIT_CYCLES = 16;
  localparam int DEF_DRAW_TIMEOUT = 4096;
endpackage

// File: rtl/enemy_control_if.sv
// enemy_control_if: frame-tick/draw/VGA handshake bundle; master = sequencer, slave = enemies/arbiter side
interface enemy_control_if;
  logic enable, frame_tick, draw_done, vga_grant;
  logic init, idle, gen_move, apply_move, draw, vga_req, frame_done, overrun, timeout;
  modport master(
    input enable, frame_tick, draw_done, vga_grant,
    output init, idle, gen_move, apply_move, draw, vga_req, frame_done, overrun, timeout
  );
  modport slave(
    output enable, frame_tick, draw_done, vga_grant,
    input init, idle, gen_move, apply_move, draw, vga_req, frame_done, overrun, timeout
  );
endinterface

// File: rtl/frame_divider.sv
// frame_divider: modulo-MOVE_DIV frame counter (clock, reset, en advances, wrap flags the last count)
module frame_divider #(
  parameter int MOVE_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic wrap
);
  localparam int W = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
  logic [W-1:0] cnt;
  assign wrap = cnt == W'(MOVE_DIV - 1);
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + 1'b1;
endmodule

// File: rtl/enemy_control.sv
// enemy_control: per-frame enemy phase sequencer (clock, reset, bus: enemy_control_if.master strobes/handshakes)
module enemy_control
  import enemy_ctrl_pkg::*;
#(
  parameter int MOVE_DIV = DEF_MOVE_DIV,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int DRAW_TIMEOUT = DEF_DRAW_TIMEOUT
) (
  input logic clock,
  input logic reset,
  enemy_control_if.master bus
);
  localparam int IW = $clog2(INIT_CYCLES + 1);
  localparam int DW = $clog2(DRAW_TIMEOUT);
  state_t state, nxt;
  logic [IW-1:0] init_cnt;
  logic [DW-1:0] draw_cnt;
  logic pending, wrap, start, tmo_hit;
  assign start = (bus.frame_tick | pending) & bus.enable;
  assign tmo_hit = (draw_cnt == DW'(DRAW_TIMEOUT - 1)) & ~bus.draw_done;
  frame_divider #(.MOVE_DIV(MOVE_DIV)) u_div (
    .clock(clock),
    .reset(reset),
    .en(state == IDLE && start),
    .wrap(wrap)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      INIT:       nxt = init_cnt == IW'(INIT_CYCLES - 1) ? IDLE : INIT;
      IDLE:       nxt = !start ? IDLE : wrap ? GEN_MOVE : REQ;
      GEN_MOVE:   nxt = APPLY_MOVE;
      APPLY_MOVE: nxt = REQ;
      REQ:        nxt = bus.vga_grant ? DRAW : REQ;
      DRAW:       nxt = bus.draw_done || tmo_hit ? DONE : DRAW;
      DONE:       nxt = IDLE;
      default:    nxt = INIT;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= INIT;
      init_cnt <= '0;
      draw_cnt <= '0;
      pending <= 1'b0;
      bus.init <= 1'b1;
      bus.idle <= 1'b0;
      bus.gen_move <= 1'b0;
      bus.apply_move <= 1'b0;
      bus.draw <= 1'b0;
      bus.vga_req <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.overrun <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state <= nxt;
      init_cnt <= state == INIT ? init_cnt + 1'b1 : '0;
      draw_cnt <= state == DRAW ? draw_cnt + 1'b1 : '0;
      pending <= state == IDLE ? pending & ~start : pending | bus.frame_tick;
      bus.overrun <= state != IDLE && bus.frame_tick && pending;
      bus.timeout <= bus.timeout | (state == DRAW && tmo_hit);
      bus.init <= nxt == INIT;
      bus.idle <= nxt == IDLE;
      bus.gen_move <= nxt == GEN_MOVE;
      bus.apply_move <= nxt == APPLY_MOVE;
      bus.draw <= nxt == DRAW;
      bus.vga_req <= nxt == REQ || nxt == DRAW;
      bus.frame_done <= nxt == DONE;
    end
endmodule
